stereolbm_frame_scheduler: RTL and testbench
============================================

# stereolbm_frame_scheduler

Per-frame sequencer for the stereo LBM HLS dataflow core. Accepts frame-available pulses from the camera ingest side and drives the core's ap_start/ap_ready/ap_done handshake, one frame at a time. A watchdog combines a frame timeout with the OR-ed output of the deadlock monitors and recovers a hung core through a soft reset. Sits between the camera sync logic and the `stereolbm_axis_cambm` core.

## Interface
- FRAME_TIMEOUT, 2000000: cycles allowed from ap_start assertion to ap_done (≥ 2).
- BLOCK_FILTER, 16: consecutive cycles deadlock_block must stay high before it counts (≥ 1).
- RST_CYCLES, 8: core_soft_rst pulse length in cycles (≥ 1).
- CNT_W, 32: watchdog counter width; must hold FRAME_TIMEOUT.
- ap_clk  in  1  sole clock.
- ap_rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  allows new frame starts.
- frame_req  in  1  single-cycle pulse: a new stereo frame is available.
- core_ap_start  out  1  HLS ap_start to the core.
- core_ap_ready  in  1  core has accepted the start.
- core_ap_done  in  1  core has finished the frame (one-cycle pulse).
- core_ap_idle  in  1  core is idle.
- deadlock_block  in  1  OR of all deadlock monitor `block` outputs.
- core_soft_rst  out  1  active-high soft reset to the core.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_dropped  out  1  one-cycle pulse per dropped or aborted frame.
- deadlock_evt  out  1  one-cycle pulse on watchdog trip.
- busy  out  1  high in every state except IDLE.
- frame_count  out  16  number of completed frames; wraps at 16 bits.
- drop_count  out  16  number of dropped plus aborted frames; wraps at 16 bits.

## Operation
- **Pending flag.** A single-entry pending flag is set by frame_req.
  - frame_req while pending is already set: frame_dropped pulses and drop_count increments. The flag stays set.
- **States:** IDLE, START, RUN, FLUSH, WAIT_IDLE.
- **IDLE**
  - enable && pending → START.
- **START**
  - core_ap_start = 1, held until core_ap_ready is sampled high.
  - On core_ap_ready → RUN, and pending is cleared.
  - If frame_req arrives in that same cycle, pending remains set; this is not a drop.
- **RUN**
  - core_ap_done → frame_done pulse, frame_count increments, → IDLE.
  - core_ap_done arriving together with core_ap_ready in START is legal. The scheduler treats it as ready followed by done and returns to IDLE.
- **Watchdog** (active in START and RUN)
  - wd_cnt clears on entry to START and increments every cycle.
  - blk_cnt counts consecutive deadlock_block cycles and clears on any low cycle.
  - Trip condition: wd_cnt == FRAME_TIMEOUT-1, or blk_cnt == BLOCK_FILTER-1 with deadlock_block high.
  - On trip → FLUSH. deadlock_evt and frame_dropped pulse, and drop_count increments.
  - If core_ap_done and the trip occur in the same cycle, done wins: normal completion, no trip.
- **FLUSH**
  - core_soft_rst is high for exactly RST_CYCLES cycles and core_ap_start is low.
  - Then → WAIT_IDLE.
- **WAIT_IDLE**
  - core_ap_idle → IDLE. This state has no timeout.
- **enable deasserted mid-frame:** the current frame completes (or trips) normally. No new START occurs while enable is low; pending is retained.

## Timing
- Reset values: all outputs 0, state IDLE, pending 0, all counters 0.
- All outputs are registered.
- frame_req high in cycle 0, with the scheduler in IDLE and enable high → core_ap_start high in cycle 2.
- core_ap_ready sampled high in cycle n → core_ap_start low in cycle n+1.
- core_ap_done sampled high in cycle n → frame_done high in cycle n+1 → next core_ap_start at the earliest in cycle n+2.
- Trip detected in cycle n → deadlock_evt and core_soft_rst high in cycle n+1.
- Reset asserted mid-frame: the scheduler returns immediately to IDLE, the in-flight frame is neither counted nor flagged, and core_soft_rst goes low.

## Configuration
- Macro: `STEREOLBM_SCHED_WATCHDOG_EN`.
- **Defined:** watchdog, BLOCK_FILTER logic and the FLUSH/WAIT_IDLE states are present as described above.
- **Undefined:**
  - The watchdog counters and the FLUSH/WAIT_IDLE states are not built.
  - deadlock_evt and core_soft_rst are tied to 0 and deadlock_block is ignored.
  - RUN waits indefinitely for core_ap_done.

## Structure
- Shared package `stereolbm_sched_pkg`: state enum `sched_state_t`, and localparams for the 16-bit counter width and the default FRAME_TIMEOUT, BLOCK_FILTER and RST_CYCLES values.
- One sub-module, `stereolbm_sched_watchdog`, containing wd_cnt, blk_cnt and the trip detect. Its inputs are run, deadlock_block and core_ap_done; its output is trip.
- It is instantiated only under `STEREOLBM_SCHED_WATCHDOG_EN`.

## Test plan
- **Single frame:** frame_req at cycle 0, core_ap_ready at cycle 5, core_ap_done at cycle 100 → core_ap_start high for cycles 2–5, frame_done at cycle 101, frame_count = 1, drop_count = 0.
- **Overflow:** three frame_req pulses during one RUN → exactly one further frame is started, frame_dropped pulses twice, drop_count = 2.
- **Timeout:** FRAME_TIMEOUT = 50, core_ap_done never asserted → deadlock_evt at cycle 50 after START entry, core_soft_rst high for 8 cycles, return to IDLE only after core_ap_idle, drop_count = 1.
- **Deadlock filter:** BLOCK_FILTER = 16.
  - deadlock_block high for 15 cycles then low → no trip.
  - deadlock_block high for 16 cycles → deadlock_evt.
- **Collision:** core_ap_done in the same cycle as the timeout trip → frame_done, no deadlock_evt, frame_count increments.
- **Async reset:** ap_rst_n pulled low mid-RUN, away from any clock edge → all outputs go to 0 immediately, state IDLE, counters 0.

Source files
------------

// File: rtl/stereolbm_sched_pkg.sv
// Shared types and defaults for the stereo LBM frame scheduler.
package stereolbm_sched_pkg;

    localparam int unsigned CNT16_W           = 16;
    localparam int unsigned DEF_FRAME_TIMEOUT = 2000000;
    localparam int unsigned DEF_BLOCK_FILTER  = 16;
    localparam int unsigned DEF_RST_CYCLES    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_FLUSH,
        ST_WAIT_IDLE
    } sched_state_t;

endpackage

// File: rtl/stereolbm_sched_watchdog.sv
// Frame timeout and filtered deadlock detection; trip is combinational and
// suppressed whenever core_ap_done is seen in the same cycle.
module stereolbm_sched_watchdog
    import stereolbm_sched_pkg::*;
#(
    parameter int unsigned FRAME_TIMEOUT = DEF_FRAME_TIMEOUT,
    parameter int unsigned BLOCK_FILTER  = DEF_BLOCK_FILTER,
    parameter int unsigned CNT_W         = 32
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic i_run,
    input  logic i_deadlock_block,
    input  logic i_core_ap_done,
    output logic o_trip
);

    localparam int unsigned BLK_W = (BLOCK_FILTER > 1) ? $clog2(BLOCK_FILTER) : 1;
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLOCK_FILTER - 1);

    logic [CNT_W-1:0] r_wd_cnt;
    logic [BLK_W-1:0] r_blk_cnt;
    logic             w_timeout;
    logic             w_blocked;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wd_cnt  <= '0;
            r_blk_cnt <= '0;
        end else if (!i_run) begin
            r_wd_cnt  <= '0;
            r_blk_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
            // Saturating: the trip leaves START/RUN before it could wrap.
            if (!i_deadlock_block)
                r_blk_cnt <= '0;
            else if (r_blk_cnt != BLK_MAX)
                r_blk_cnt <= r_blk_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_wd_cnt == CNT_W'(FRAME_TIMEOUT - 1));
    assign w_blocked = i_deadlock_block && (r_blk_cnt == BLK_MAX);
    assign o_trip    = i_run && !i_core_ap_done && (w_timeout || w_blocked);

endmodule

// File: rtl/stereolbm_frame_scheduler.sv
// Per-frame ap_start/ap_done sequencer for the stereo LBM core.
// Watchdog, soft-reset flush and idle wait built only with STEREOLBM_SCHED_WATCHDOG_EN.
module stereolbm_frame_scheduler
    import stereolbm_sched_pkg::*;
#(
    parameter int unsigned FRAME_TIMEOUT = DEF_FRAME_TIMEOUT,
    parameter int unsigned BLOCK_FILTER  = DEF_BLOCK_FILTER,
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned CNT_W         = 32
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               enable,
    input  logic               frame_req,
    output logic               core_ap_start,
    input  logic               core_ap_ready,
    input  logic               core_ap_done,
    input  logic               core_ap_idle,
    input  logic               deadlock_block,
    output logic               core_soft_rst,
    output logic               frame_done,
    output logic               frame_dropped,
    output logic               deadlock_evt,
    output logic               busy,
    output logic [CNT16_W-1:0] frame_count,
    output logic [CNT16_W-1:0] drop_count
);

    sched_state_t r_state;
    logic         r_pending;
    logic         w_run;
    logic         w_trip;
    logic         w_accept;
    logic         w_dup;
    logic [1:0]   w_drop_inc;

    assign w_run = (r_state == ST_START) || (r_state == ST_RUN);

`ifdef STEREOLBM_SCHED_WATCHDOG_EN
    logic [CNT_W-1:0] r_rst_cnt;

    stereolbm_sched_watchdog #(
        .FRAME_TIMEOUT (FRAME_TIMEOUT),
        .BLOCK_FILTER  (BLOCK_FILTER),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .i_run            (w_run),
        .i_deadlock_block (deadlock_block),
        .i_core_ap_done   (core_ap_done),
        .o_trip           (w_trip)
    );
`else
    logic w_unused;

    assign w_trip        = 1'b0;
    assign core_soft_rst = 1'b0;
    assign deadlock_evt  = 1'b0;
    assign w_unused      = deadlock_block ^ core_ap_idle ^ w_run ^ (FRAME_TIMEOUT == 0)
                         ^ (BLOCK_FILTER == 0) ^ (RST_CYCLES == 0) ^ (CNT_W == 0);
`endif

    // The pending frame is consumed when the core accepts it or when it is aborted.
    assign w_accept   = (r_state == ST_START) && (core_ap_ready || w_trip);
    assign w_dup      = frame_req && r_pending && !w_accept;
    assign w_drop_inc = {1'b0, w_dup} + {1'b0, w_trip};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= ST_IDLE;
            r_pending     <= 1'b0;
            core_ap_start <= 1'b0;
            frame_done    <= 1'b0;
            frame_dropped <= 1'b0;
            busy          <= 1'b0;
            frame_count   <= '0;
            drop_count    <= '0;
`ifdef STEREOLBM_SCHED_WATCHDOG_EN
            r_rst_cnt     <= '0;
            core_soft_rst <= 1'b0;
            deadlock_evt  <= 1'b0;
`endif
        end else begin
            frame_done    <= 1'b0;
            frame_dropped <= w_dup || w_trip;
            drop_count    <= drop_count + CNT16_W'(w_drop_inc);
            r_pending     <= frame_req || (r_pending && !w_accept);
`ifdef STEREOLBM_SCHED_WATCHDOG_EN
            deadlock_evt  <= 1'b0;
            if (w_trip) begin
                r_state       <= ST_FLUSH;
                core_ap_start <= 1'b0;
                core_soft_rst <= 1'b1;
                deadlock_evt  <= 1'b1;
                r_rst_cnt     <= '0;
            end
`endif
            case (r_state)
                ST_IDLE: begin
                    if (enable && r_pending) begin
                        r_state       <= ST_START;
                        core_ap_start <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                ST_START: begin
                    // Ready together with done completes the frame in one step.
                    if (core_ap_ready && core_ap_done) begin
                        r_state       <= ST_IDLE;
                        core_ap_start <= 1'b0;
                        busy          <= 1'b0;
                        frame_done    <= 1'b1;
                        frame_count   <= frame_count + 1'b1;
                    end else if (core_ap_ready && !w_trip) begin
                        r_state       <= ST_RUN;
                        core_ap_start <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (core_ap_done) begin
                        r_state     <= ST_IDLE;
                        busy        <= 1'b0;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                    end
                end
`ifdef STEREOLBM_SCHED_WATCHDOG_EN
                ST_FLUSH: begin
                    if (r_rst_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        r_state       <= ST_WAIT_IDLE;
                        core_soft_rst <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (core_ap_idle) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state       <= ST_IDLE;
                    core_ap_start <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stereolbm_frame_scheduler.sv
// Randomized and directed bench for stereolbm_frame_scheduler with a behavioural model.
module tb_stereolbm_frame_scheduler;

    localparam int unsigned FT = 120;
    localparam int unsigned BF = 16;
    localparam int unsigned RC = 8;
`ifdef STEREOLBM_SCHED_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        enable = 1'b0, frame_req = 1'b0, core_ap_ready = 1'b0;
    logic        core_ap_done = 1'b0, core_ap_idle = 1'b0, deadlock_block = 1'b0;
    logic        core_ap_start, core_soft_rst, frame_done, frame_dropped, deadlock_evt, busy;
    logic [15:0] frame_count, drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    stereolbm_frame_scheduler #(
        .FRAME_TIMEOUT (FT),
        .BLOCK_FILTER  (BF),
        .RST_CYCLES    (RC),
        .CNT_W         (32)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .enable         (enable),
        .frame_req      (frame_req),
        .core_ap_start  (core_ap_start),
        .core_ap_ready  (core_ap_ready),
        .core_ap_done   (core_ap_done),
        .core_ap_idle   (core_ap_idle),
        .deadlock_block (deadlock_block),
        .core_soft_rst  (core_soft_rst),
        .frame_done     (frame_done),
        .frame_dropped  (frame_dropped),
        .deadlock_evt   (deadlock_evt),
        .busy           (busy),
        .frame_count    (frame_count),
        .drop_count     (drop_count)
    );

    always #5 ap_clk = ~ap_clk;

    // Behavioural model: phase of the current frame plus elapsed-time counters.
    typedef enum {M_IDLE, M_START, M_RUN, M_FLUSH, M_WAIT} mph_t;
    mph_t ph;
    bit   pend, e_fdone, e_fdrop, e_devt;
    int   age, brun, fleft, fcnt, dcnt;

    task automatic model_reset();
        ph = M_IDLE; pend = 0; age = 0; brun = 0; fleft = 0;
        fcnt = 0; dcnt = 0; e_fdone = 0; e_fdrop = 0; e_devt = 0;
    endtask

    task automatic model_step();
        bit   act, trip, acc, dup;
        mph_t nph;
        act  = (ph == M_START) || (ph == M_RUN);
        trip = 0;
        if (WD && act && !core_ap_done)
            trip = (age == int'(FT) - 1) || (deadlock_block && (brun + 1 >= int'(BF)));
        acc = (ph == M_START) && (core_ap_ready || trip);
        dup = frame_req && pend && !acc;
        e_fdone = 0;
        e_devt  = trip;
        e_fdrop = dup || trip;
        dcnt    = dcnt + int'(dup) + int'(trip);
        nph = ph;
        case (ph)
            M_IDLE:  if (enable && pend) nph = M_START;
            M_START: begin
                if (core_ap_ready && core_ap_done) begin nph = M_IDLE; e_fdone = 1; fcnt++; end
                else if (trip) nph = M_FLUSH;
                else if (core_ap_ready) nph = M_RUN;
            end
            M_RUN: begin
                if (core_ap_done) begin nph = M_IDLE; e_fdone = 1; fcnt++; end
                else if (trip) nph = M_FLUSH;
            end
            M_FLUSH: begin fleft--; if (fleft == 0) nph = M_WAIT; end
            M_WAIT:  if (core_ap_idle) nph = M_IDLE;
            default: nph = M_IDLE;
        endcase
        if (nph == M_FLUSH && ph != M_FLUSH) fleft = RC;
        brun = (act && deadlock_block) ? brun + 1 : 0;
        age  = (ph == M_IDLE) ? 0 : age + 1;
        pend = frame_req || (pend && !acc);
        ph   = nph;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge ap_clk) begin
        if (chk_on) begin
            chk("ap_start", core_ap_start, ph == M_START);
            chk("soft_rst", core_soft_rst, ph == M_FLUSH);
            chk("busy", busy, ph != M_IDLE);
            chk("frame_done", frame_done, e_fdone);
            chk("frame_dropped", frame_dropped, e_fdrop);
            chk("deadlock_evt", deadlock_evt, e_devt);
            chk("frame_count", frame_count, fcnt & 'hFFFF);
            chk("drop_count", drop_count, dcnt & 'hFFFF);
        end
    end

    task automatic drive(input bit en, input bit req, input bit rdy, input bit done,
                         input bit idle, input bit blk);
        enable = en; frame_req = req; core_ap_ready = rdy;
        core_ap_done = done; core_ap_idle = idle; deadlock_block = blk;
        @(posedge ap_clk);
        model_step();
        @(negedge ap_clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_start"}, core_ap_start, 0);
        chk({tag, "_srst"}, core_soft_rst, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_evt"}, {frame_done, frame_dropped, deadlock_evt}, 0);
        chk({tag, "_fcnt"}, frame_count, 0);
        chk({tag, "_dcnt"}, drop_count, 0);
    endtask

    task automatic do_reset();
        chk_on = 0;
        enable = 0; frame_req = 0; core_ap_ready = 0;
        core_ap_done = 0; core_ap_idle = 0; deadlock_block = 0;
        ap_rst_n = 0;
        repeat (3) @(negedge ap_clk);
        model_reset();
        check_all_zero("reset");
        ap_rst_n = 1;
        chk_on = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int st_first, st_last, st_cnt, fd_cyc, starts, drops, devt_cyc, devt_n, srst_n, srst_first;
        bit prev_start, busy140, busy141;
        int  bcnt, dmod;

        // Single frame
        do_reset();
        st_first = -1; st_last = -1; st_cnt = 0; fd_cyc = -1;
        for (int k = 0; k <= 110; k++) begin
            if (core_ap_start) begin
                if (st_first < 0) st_first = k;
                st_last = k; st_cnt++;
            end
            if (frame_done) fd_cyc = k;
            drive(1, k == 0, k == 5, k == 100, 0, 0);
        end
        chk("single_start_first", st_first, 2);
        chk("single_start_last", st_last, 5);
        chk("single_start_len", st_cnt, 4);
        chk("single_done_cycle", fd_cyc, 101);
        chk("single_fcnt", frame_count, 1);
        chk("single_dcnt", drop_count, 0);

        // Overflow: three requests during one RUN
        do_reset();
        starts = 0; drops = 0; prev_start = 0;
        for (int k = 0; k <= 60; k++) begin
            if (core_ap_start && !prev_start) starts++;
            prev_start = core_ap_start;
            if (frame_dropped) drops++;
            drive(1, k == 0 || k == 10 || k == 12 || k == 14, k == 4 || k == 35,
                  k == 30 || k == 40, 0, 0);
        end
        chk("ovf_starts", starts, 2);
        chk("ovf_drop_pulses", drops, 2);
        chk("ovf_dcnt", drop_count, 2);
        chk("ovf_fcnt", frame_count, 2);

        // Timeout with core never done
        do_reset();
        devt_cyc = -1; devt_n = 0; srst_n = 0; srst_first = -1; busy140 = 0; busy141 = 0;
        for (int k = 0; k <= 150; k++) begin
            if (deadlock_evt) begin devt_n++; devt_cyc = k; end
            if (core_soft_rst) begin srst_n++; if (srst_first < 0) srst_first = k; end
            if (k == 140) busy140 = busy;
            if (k == 141) busy141 = busy;
            drive(1, k == 0, k == 3, 0, k >= 140, 0);
        end
`ifdef STEREOLBM_SCHED_WATCHDOG_EN
        chk("tmo_evt_cycle", devt_cyc, 2 + FT);
        chk("tmo_evt_count", devt_n, 1);
        chk("tmo_srst_first", srst_first, 2 + FT);
        chk("tmo_srst_len", srst_n, RC);
        chk("tmo_busy_wait", busy140, 1);
        chk("tmo_busy_idle", busy141, 0);
        chk("tmo_dcnt", drop_count, 1);
`else
        chk("tmo_evt_count", devt_n, 0);
        chk("tmo_srst_len", srst_n, 0);
        chk("tmo_busy_run", busy141, 1);
        chk("tmo_dcnt", drop_count, 0);
`endif

        // Deadlock filter: 15-cycle burst then 16-cycle burst
        do_reset();
        devt_cyc = -1; devt_n = 0;
        for (int k = 0; k <= 80; k++) begin
            if (deadlock_evt) begin devt_n++; devt_cyc = k; end
            drive(1, k == 0, k == 3, 0, 0, (k >= 10 && k <= 24) || (k >= 40 && k <= 55));
        end
`ifdef STEREOLBM_SCHED_WATCHDOG_EN
        chk("blk_evt_count", devt_n, 1);
        chk("blk_evt_cycle", devt_cyc, 56);
`else
        chk("blk_evt_count", devt_n, 0);
`endif

        // Done collides with timeout trip
        do_reset();
        fd_cyc = -1; devt_n = 0;
        for (int k = 0; k <= 130; k++) begin
            if (frame_done) fd_cyc = k;
            if (deadlock_evt) devt_n++;
            drive(1, k == 0, k == 3, k == 1 + FT, 0, 0);
        end
        chk("coll_done_cycle", fd_cyc, 2 + FT);
        chk("coll_evt_count", devt_n, 0);
        chk("coll_fcnt", frame_count, 1);
        chk("coll_dcnt", drop_count, 0);

        // Asynchronous reset mid-RUN, away from clock edges
        do_reset();
        for (int k = 0; k <= 20; k++) drive(1, k == 0, k == 3, 0, 0, 0);
        chk("arst_busy_before", busy, 1);
        chk_on = 0;
        @(posedge ap_clk);
        #2 ap_rst_n = 0;
        #1 check_all_zero("arst");
        model_reset();
        @(negedge ap_clk);
        ap_rst_n = 1;
        chk_on = 1;

        // Randomized traffic against the model
        bcnt = 0; dmod = 8;
        enable = 1;
        for (int k = 0; k < 4000; k++) begin
            bit en, req, rdy, done, idle, blk;
            if (k % 500 == 0) dmod = ($urandom_range(0, 1) == 0) ? 8 : 300;
            en   = ($urandom_range(0, 49) == 0) ? !enable : enable;
            req  = ($urandom_range(0, 19) == 0);
            rdy  = (ph == M_START) && ($urandom_range(0, 2) == 0);
            if (ph == M_RUN)
                done = ($urandom_range(0, dmod - 1) == 0);
            else
                done = rdy && ($urandom_range(0, 3) == 0);
            idle = ($urandom_range(0, 3) == 0);
            if (bcnt > 0) begin
                blk = 1; bcnt--;
            end else begin
                blk = 0;
                if ($urandom_range(0, 29) == 0) bcnt = $urandom_range(5, 20);
            end
            drive(en, req, rdy, done, idle, blk);
        end

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
